// File: rtl/pe_pkg.sv
// pe_pkg: constants and types shared by the PE, the psum accumulator and the writeback stage.
package pe_pkg;
   localparam int DEF_N = 8;
   localparam int DEF_ACC_W = 20;
   localparam int NUM_LANES = 3;
   typedef enum logic {IDLE, ACCUM} state_e;
   function automatic int cnt_w(input int len);
      return $clog2(len) + 1;
   endfunction
endpackage

// File: rtl/psum_accumulator_if.sv
// psum_accumulator_if: PE beat input and result output handshakes of the accumulator.
interface psum_accumulator_if import pe_pkg::*; #(
   parameter int N = DEF_N,
   parameter int ACC_W = DEF_ACC_W
);
   logic in_valid, in_ready, out_valid, out_ready;
   logic [2*N-1:0] psum0, psum1, psum2;
   logic [ACC_W-1:0] res0, res1, res2;
   modport master (output in_valid, psum0, psum1, psum2, out_ready,
                   input in_ready, out_valid, res0, res1, res2);
   modport slave (input in_valid, psum0, psum1, psum2, out_ready,
                  output in_ready, out_valid, res0, res1, res2);
endinterface

// File: rtl/psum_fifo.sv
// psum_fifo: synchronous result FIFO with registered occupancy count.
module psum_fifo #(
   parameter int W = 60,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0] cnt_q;
   logic do_push, do_pop;
   assign full_o = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_push = push_i && !full_o;
   assign do_pop = pop_i && !empty_o;
   // an empty FIFO presents zeros so stale storage never leaks onto the result bus
   assign dout_o = empty_o ? '0 : mem_q[rd_q];
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= din_i;
   always_ff @(posedge clk)
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_q + AW'(do_push);
         rd_q <= rd_q + AW'(do_pop);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: sums ACC_LEN PE beats per lane with saturation and queues results for writeback.
module psum_accumulator import pe_pkg::*; #(
   parameter int N = DEF_N,
   parameter int ACC_W = DEF_ACC_W,
   parameter int ACC_LEN = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   psum_accumulator_if.slave        bus,
   output logic [$clog2(ACC_LEN):0] beat_cnt,
   output logic                     sat_flag
);
   localparam int CW = cnt_w(ACC_LEN);
   state_e state_q, state_d;
   logic [ACC_W-1:0] acc_q [NUM_LANES];
   logic [ACC_W-1:0] acc_d [NUM_LANES];
   logic [ACC_W-1:0] sat [NUM_LANES];
   logic [ACC_W:0] sum [NUM_LANES];
   logic [2*N-1:0] psum [NUM_LANES];
   logic [NUM_LANES-1:0] ovf;
   logic [CW-1:0] cnt_q, cnt_d;
   logic sat_q, sat_d, last, fire, full, empty;
   logic [3*ACC_W-1:0] head;
   assign psum = '{bus.psum0, bus.psum1, bus.psum2};
   assign last = cnt_q == CW'(ACC_LEN - 1);
   // only the result-producing beat needs FIFO room; the registered full keeps this path short
   assign bus.in_ready = state_q == ACCUM && !start && !(last && full);
   assign fire = bus.in_valid && bus.in_ready;
   assign bus.out_valid = !empty;
   assign bus.res0 = head[ACC_W-1:0];
   assign bus.res1 = head[2*ACC_W-1:ACC_W];
   assign bus.res2 = head[3*ACC_W-1:2*ACC_W];
   assign beat_cnt = cnt_q;
   assign sat_flag = sat_q;
   always_comb begin
      state_d = (state_q == IDLE && start) ? ACCUM : state_q;
      cnt_d = start ? '0 : fire ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
      for (int i = 0; i < NUM_LANES; i++) begin
         sum[i] = {1'b0, acc_q[i]} + (ACC_W+1)'(psum[i]);
         ovf[i] = sum[i][ACC_W];
         sat[i] = ovf[i] ? '1 : sum[i][ACC_W-1:0];
         acc_d[i] = (start || (fire && last)) ? '0 : fire ? sat[i] : acc_q[i];
      end
      sat_d = !start && (sat_q || (fire && |ovf));
   end
   always_ff @(posedge clk)
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         sat_q <= 1'b0;
         acc_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         sat_q <= sat_d;
         acc_q <= acc_d;
      end
   psum_fifo #(.W(3*ACC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (fire && last),
      .pop_i   (bus.out_ready),
      .din_i   ({sat[2], sat[1], sat[0]}),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed checks of accumulation, backpressure, saturation, restart and reset.
module tb_psum_accumulator;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic sstart = 1'b0;
   logic [2:0] beat_cnt, s_beat_cnt;
   logic sat_flag, s_sat_flag;
   int checks = 0;
   int errors = 0;
   psum_accumulator_if #(.N(8), .ACC_W(20)) bus ();
   psum_accumulator_if #(.N(8), .ACC_W(17)) sbus ();
   psum_accumulator #(.N(8), .ACC_W(20), .ACC_LEN(3), .FIFO_DEPTH(4)) u_dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus), .beat_cnt(beat_cnt), .sat_flag(sat_flag));
   psum_accumulator #(.N(8), .ACC_W(17), .ACC_LEN(3), .FIFO_DEPTH(4)) u_sat (
      .clk(clk), .reset(reset), .start(sstart), .bus(sbus), .beat_cnt(s_beat_cnt), .sat_flag(s_sat_flag));
   always #5 clk = ~clk;

   task automatic pulse_start;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send(input int a, input int b, input int c);
      int n = 0;
      bus.in_valid = 1'b1; bus.psum0 = 16'(a); bus.psum1 = 16'(b); bus.psum2 = 16'(c);
      #1;
      while (!bus.in_ready && n < 20) begin @(negedge clk); #1; n++; end
      if (!bus.in_ready) begin errors++; $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready); end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", bus.in_ready); end
      checks++; if (beat_cnt !== 3'd0) begin errors++; $display("FAIL reset_beat_cnt: got %0d expected 0", beat_cnt); end
      checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %0b expected 0", sat_flag); end
      checks++; if (bus.res0 !== 20'd0) begin errors++; $display("FAIL reset_res0: got %0d expected 0", bus.res0); end
      reset = 1'b0;
   endtask

   task automatic test_idle;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.psum0 = 16'd5; bus.psum1 = 16'd5; bus.psum2 = 16'd5;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %0b expected 0", bus.in_ready); end
      repeat (4) @(negedge clk);
      checks++; if (beat_cnt !== 3'd0) begin errors++; $display("FAIL idle_beat_cnt: got %0d expected 0", beat_cnt); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %0b expected 0", bus.out_valid); end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_basic;
      bus.out_ready = 1'b1;
      pulse_start();
      send(4, 1, 0);
      send(5, 2, 0);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b expected 0", bus.out_valid); end
      checks++; if (beat_cnt !== 3'd2) begin errors++; $display("FAIL basic_beat_cnt: got %0d expected 2", beat_cnt); end
      send(6, 3, 7);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %0b expected 1", bus.out_valid); end
      checks++; if (bus.res0 !== 20'd15) begin errors++; $display("FAIL basic_res0: got %0d expected 15", bus.res0); end
      checks++; if (bus.res1 !== 20'd6) begin errors++; $display("FAIL basic_res1: got %0d expected 6", bus.res1); end
      checks++; if (bus.res2 !== 20'd7) begin errors++; $display("FAIL basic_res2: got %0d expected 7", bus.res2); end
      checks++; if (beat_cnt !== 3'd0) begin errors++; $display("FAIL basic_cnt_wrap: got %0d expected 0", beat_cnt); end
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_single_result: got %0b expected 0", bus.out_valid); end
   endtask

   task automatic test_backpressure;
      int k = 0;
      logic acc;
      bus.out_ready = 1'b0;
      pulse_start();
      for (int r = 0; r < 5; r++)
         for (int b = 0; b < 3; b++) begin
            bus.in_valid = 1'b1; bus.psum0 = 16'(r*10 + b); bus.psum1 = 16'(r); bus.psum2 = 16'(b + 1);
            #1;
            checks++;
            if (bus.in_ready !== ((r == 4 && b == 2) ? 1'b0 : 1'b1)) begin
               errors++; $display("FAIL bp_in_ready r=%0d b=%0d: got %0b", r, b, bus.in_ready);
            end
            if (!(r == 4 && b == 2)) @(negedge clk);
         end
      @(negedge clk); #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_held: got %0b expected 0", bus.in_ready); end
      checks++; if (beat_cnt !== 3'd2) begin errors++; $display("FAIL bp_beat_cnt: got %0d expected 2", beat_cnt); end
      checks++; if (bus.res0 !== 20'd3) begin errors++; $display("FAIL bp_head: got %0d expected 3", bus.res0); end
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 30 && k < 5; cyc++) begin
         #1;
         acc = bus.in_valid && bus.in_ready;
         if (bus.out_valid) begin
            checks++; if (bus.res0 !== 20'(30*k + 3)) begin errors++; $display("FAIL bp_res0[%0d]: got %0d expected %0d", k, bus.res0, 30*k + 3); end
            checks++; if (bus.res1 !== 20'(3*k)) begin errors++; $display("FAIL bp_res1[%0d]: got %0d expected %0d", k, bus.res1, 3*k); end
            checks++; if (bus.res2 !== 20'd6) begin errors++; $display("FAIL bp_res2[%0d]: got %0d expected 6", k, bus.res2); end
            k++;
         end
         @(negedge clk);
         if (acc) bus.in_valid = 1'b0;
      end
      checks++; if (k != 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", k); end
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b expected 0", bus.out_valid); end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_start_mid;
      bus.out_ready = 1'b1;
      pulse_start();
      send(10, 10, 10);
      send(20, 20, 20);
      checks++; if (beat_cnt !== 3'd2) begin errors++; $display("FAIL mid_cnt_before: got %0d expected 2", beat_cnt); end
      start = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_start_ready: got %0b expected 0", bus.in_ready); end
      @(negedge clk); start = 1'b0;
      checks++; if (beat_cnt !== 3'd0) begin errors++; $display("FAIL mid_cnt_cleared: got %0d expected 0", beat_cnt); end
      send(1, 1, 1); send(2, 2, 2); send(3, 3, 3);
      checks++; if (bus.res0 !== 20'd6) begin errors++; $display("FAIL mid_res0: got %0d expected 6", bus.res0); end
      @(negedge clk);
      send(1, 1, 1);
      start = 1'b1; bus.in_valid = 1'b1; bus.psum0 = 16'd100; bus.psum1 = 16'd100; bus.psum2 = 16'd100;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_collide_ready: got %0b expected 0", bus.in_ready); end
      @(negedge clk); start = 1'b0; bus.in_valid = 1'b0;
      checks++; if (beat_cnt !== 3'd0) begin errors++; $display("FAIL mid_collide_cnt: got %0d expected 0", beat_cnt); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_collide_valid: got %0b expected 0", bus.out_valid); end
      send(1, 1, 1); send(2, 2, 2); send(3, 3, 3);
      checks++; if (bus.res1 !== 20'd6) begin errors++; $display("FAIL mid_collide_res1: got %0d expected 6", bus.res1); end
      @(negedge clk);
   endtask

   task automatic test_push_pop;
      bus.out_ready = 1'b0;
      pulse_start();
      for (int r = 0; r < 2; r++) repeat (3) send(r + 1, r + 1, r + 1);
      send(3, 3, 3); send(3, 3, 3);
      bus.in_valid = 1'b1; bus.psum0 = 16'd3; bus.psum1 = 16'd3; bus.psum2 = 16'd3; bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL pp_in_ready: got %0b expected 1", bus.in_ready); end
      @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      checks++; if (bus.res0 !== 20'd6) begin errors++; $display("FAIL pp_head1: got %0d expected 6", bus.res0); end
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.res0 !== 20'd9) begin errors++; $display("FAIL pp_head2: got %0d expected 9", bus.res0); end
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pp_count: got %0b expected 0", bus.out_valid); end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      bus.out_ready = 1'b0;
      repeat (10) send(1, 1, 1);
      checks++; if (beat_cnt !== 3'd1) begin errors++; $display("FAIL rm_cnt: got %0d expected 1", beat_cnt); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rm_queued: got %0b expected 1", bus.out_valid); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %0b expected 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rm_in_ready: got %0b expected 0", bus.in_ready); end
      checks++; if (beat_cnt !== 3'd0) begin errors++; $display("FAIL rm_beat_cnt: got %0d expected 0", beat_cnt); end
      reset = 1'b0; bus.in_valid = 1'b1;
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rm_idle: got %0b expected 0", bus.in_ready); end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_saturation;
      sbus.out_ready = 1'b1;
      @(negedge clk); sstart = 1'b1;
      @(negedge clk); sstart = 1'b0;
      for (int b = 0; b < 3; b++) begin
         sbus.in_valid = 1'b1; sbus.psum0 = 16'hFFFF; sbus.psum1 = 16'hFFFF; sbus.psum2 = 16'hFFFF;
         #1;
         checks++; if (sbus.in_ready !== 1'b1) begin errors++; $display("FAIL sat_in_ready b=%0d: got %0b expected 1", b, sbus.in_ready); end
         @(negedge clk);
         if (b == 1) begin
            checks++; if (s_sat_flag !== 1'b0) begin errors++; $display("FAIL sat_early: got %0b expected 0", s_sat_flag); end
         end
      end
      sbus.in_valid = 1'b0;
      checks++; if (sbus.out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %0b expected 1", sbus.out_valid); end
      checks++; if (sbus.res0 !== 17'd131071) begin errors++; $display("FAIL sat_res0: got %0d expected 131071", sbus.res0); end
      checks++; if (sbus.res2 !== 17'd131071) begin errors++; $display("FAIL sat_res2: got %0d expected 131071", sbus.res2); end
      checks++; if (s_sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag: got %0b expected 1", s_sat_flag); end
      sstart = 1'b1;
      @(negedge clk); sstart = 1'b0;
      checks++; if (s_sat_flag !== 1'b0) begin errors++; $display("FAIL sat_cleared: got %0b expected 0", s_sat_flag); end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.psum0 = '0; bus.psum1 = '0; bus.psum2 = '0;
      sbus.in_valid = 1'b0; sbus.out_ready = 1'b1; sbus.psum0 = '0; sbus.psum1 = '0; sbus.psum2 = '0;
      test_reset();
      test_idle();
      test_basic();
      test_backpressure();
      test_start_mid();
      test_push_pop();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
